tournament_chooser: RTL and testbench
=====================================

// Module: tournament_chooser
// PURPOSE
//  Meta-predictor downstream of the global (GBP) and local (LBP) direction predictors.
//  Per-PC table of 2-bit saturating chooser counters selects which prediction drives IF next-PC.
//  Keeps a DELAY-deep record of every IF lookup; trains on ID resolution DELAY unstalled cycles later.
//  Maintains resolved-branch / correct-prediction performance counters.
// PARAMETERS
//  INDEX  12  chooser index width; table depth = 2**INDEX
//  DELAY  7   unstalled cycles from IF lookup to ID resolution of the same PC (>=2)
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-low reset
//  stall       in   1   pipeline stall; freezes all state
//  if_pc       in   32  PC being fetched
//  gbp_pred    in   1   global predictor direction for if_pc
//  lbp_pred    in   1   local predictor direction for if_pc
//  is_branch   in   1   ID: resolved instruction is a conditional branch
//  is_taken    in   1   ID: resolved direction (valid with is_branch)
//  pred        out  1   final direction prediction for if_pc
//  use_global  out  1   1 = pred taken from gbp_pred
//  stat_branch out  32  count of resolved branches
//  stat_correct out 32  count of resolved branches whose final pred matched is_taken
// BEHAVIOUR
//  - idx = if_pc[INDEX+1:2]; table read combinational, same cycle as if_pc.
//  - use_global = table[idx][1]; pred = use_global ? gbp_pred : lbp_pred. No registered latency.
//  - Record pipe, DELAY entries of {idx, gbp_pred, lbp_pred, pred}:
//    every cycle with stall=0, entry DELAY-1 <= current IF values, entry k <= entry k+1.
//    entry 0 = lookup made DELAY unstalled cycles ago; it pairs with the current is_branch/is_taken.
//  - Training (stall=0 and is_branch=1), counter c = table[entry0.idx]:
//    g_ok = (entry0.gbp == is_taken), l_ok = (entry0.lbp == is_taken)
//    g_ok & !l_ok -> c = min(c+1, 3); !g_ok & l_ok -> c = max(c-1, 0); otherwise unchanged.
//    Counters saturate at 0/3 and never wrap.
//  - Stats (stall=0 and is_branch=1): stat_branch += 1; stat_correct += (entry0.pred == is_taken).
//    Both saturate at 32'hFFFF_FFFF (hold, no wrap).
//  - Same-index read and write in one cycle: pred/use_global use pre-update value;
//    the update is visible the following cycle.
//  - stall=1: no pipe shift, no table write, stats hold; pred/use_global still track if_pc.
//  - is_branch=0: pipe still shifts, no table write, stats unchanged.
//  - Reset (async, any time, incl. mid-training): all table counters = 2'b01 (weakly local),
//    all pipe entries = 0, stat_branch = stat_correct = 0.
//    After reset use_global = 0 and pred = lbp_pred combinationally.
//    First DELAY unstalled cycles train against zeroed entries (idx 0, preds 0); accepted.
//  - Reset deassertion is synchronous to clk in the system; no reset-release sequencing here.
// TESTING
//  T1 reset: reset=0 mid-run -> use_global=0 every idx, stats=0,
//     pred==lbp_pred for gbp/lbp = 1/0 and 0/1.
//  T2 train toward global: PC 0x400 with gbp=1, lbp=0, is_taken=1 resolved twice, DELAY=7
//     -> counter 01->10->11, use_global=1 at PC 0x400; a third win keeps it at 11.
//  T3 train toward local: from 11, two resolutions with gbp wrong, lbp right -> 11->10->01, use_global=0;
//     further wins saturate at 00; both-right or both-wrong -> unchanged.
//  T4 stall: stall=1 for 5 cycles with is_branch=1 -> no counter change, stats hold;
//     on release the resolution pairs with the entry recorded exactly DELAY unstalled cycles earlier.
//  T5 read/write collision: update idx 5 while if_pc maps to idx 5 -> pred uses old counter
//     that cycle, new counter next cycle.
//  T6 stats: 10 resolved branches, 7 correct -> stat_branch=10, stat_correct=7;
//     force 32'hFFFF_FFFE plus 3 resolutions -> holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/tournament_chooser.sv
`default_nettype none
// ============================================================================
// Module   : tournament_chooser
// Purpose  : Tournament meta-predictor. A per-PC table of 2-bit saturating
//            chooser counters decides whether the global (GBP) or the local
//            (LBP) direction prediction drives the IF next-PC. Every IF lookup
//            is remembered for DELAY unstalled cycles so that the matching ID
//            resolution can train the counter that made the choice. Resolved
//            branch and correct-prediction counts are kept for profiling.
// Ports    : clk          - clock
//            reset        - asynchronous, active-low reset
//            stall        - pipeline stall, freezes all state
//            if_pc        - PC being fetched
//            gbp_pred     - global predictor direction for if_pc
//            lbp_pred     - local predictor direction for if_pc
//            is_branch    - ID: resolved instruction is a conditional branch
//            is_taken     - ID: resolved direction (valid with is_branch)
//            pred         - final direction prediction for if_pc
//            use_global   - 1 = pred taken from gbp_pred
//            stat_branch  - saturating count of resolved branches
//            stat_correct - saturating count of correctly predicted branches
// Revision : 1.0 - initial release
// ============================================================================
module tournament_chooser #(
  parameter int INDEX = 12,
  parameter int DELAY = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] if_pc,
  input  logic        gbp_pred,
  input  logic        lbp_pred,
  input  logic        is_branch,
  input  logic        is_taken,
  output logic        pred,
  output logic        use_global,
  output logic [31:0] stat_branch,
  output logic [31:0] stat_correct
);

  localparam int          DEPTH     = 2 ** INDEX;
  localparam logic [1:0]  CNT_RESET = 2'b01;   // weakly prefer local
  localparam logic [1:0]  CNT_MAX   = 2'b11;
  localparam logic [1:0]  CNT_MIN   = 2'b00;
  localparam logic [31:0] STAT_MAX  = 32'hFFFF_FFFF;

  // One remembered IF lookup: which counter was used and what each
  // predictor (and the final choice) said at that time.
  typedef struct packed {
    logic [INDEX-1:0] idx;
    logic             gbp;
    logic             lbp;
    logic             pred;
  } lookup_rec_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [1:0]  chooser [DEPTH];
  lookup_rec_t history [DELAY];
  logic [31:0] branch_count;
  logic [31:0] correct_count;

  // --------------------------------------------------------------------------
  // IF-side lookup (purely combinational, same cycle as if_pc)
  // --------------------------------------------------------------------------
  logic [INDEX-1:0] lookup_idx;
  lookup_rec_t      lookup_rec;

  assign lookup_idx = if_pc[INDEX+1:2];

  // The table write below is non-blocking, so a same-cycle update to
  // lookup_idx is only seen on the following cycle.
  assign use_global = chooser[lookup_idx][1];
  assign pred       = use_global ? gbp_pred : lbp_pred;

  assign lookup_rec = '{idx: lookup_idx, gbp: gbp_pred, lbp: lbp_pred, pred: pred};

  // Word-alignment bits and PC bits above the index never select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:INDEX+2], if_pc[1:0]};

  // --------------------------------------------------------------------------
  // ID-side training
  // --------------------------------------------------------------------------
  lookup_rec_t resolved;
  logic        train_en;
  logic        gbp_ok;
  logic        lbp_ok;
  logic [1:0]  train_cnt;
  logic [1:0]  train_next;

  // history[0] is the lookup made DELAY unstalled cycles ago, i.e. the fetch
  // of the instruction that ID is resolving right now.
  assign resolved = history[0];
  assign train_en = !stall && is_branch;
  assign gbp_ok   = (resolved.gbp == is_taken);
  assign lbp_ok   = (resolved.lbp == is_taken);
  assign train_cnt = chooser[resolved.idx];

  // Only move when exactly one predictor was right; agreement carries no
  // information about which predictor to trust.
  always_comb begin
    train_next = train_cnt;
    if (gbp_ok && !lbp_ok) begin
      if (train_cnt != CNT_MAX) begin
        train_next = train_cnt + 2'd1;
      end
    end else if (!gbp_ok && lbp_ok) begin
      if (train_cnt != CNT_MIN) begin
        train_next = train_cnt - 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Chooser counter table
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        chooser[i] <= CNT_RESET;
      end
    end else if (train_en) begin
      chooser[resolved.idx] <= train_next;
    end
  end

  // --------------------------------------------------------------------------
  // Lookup history pipe: newest entry at DELAY-1, oldest at 0.
  // It advances on every unstalled cycle, branch or not, so that the age of
  // entry 0 always matches the instruction reaching ID.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DELAY; k++) begin
        history[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < DELAY - 1; k++) begin
        history[k] <= history[k+1];
      end
      history[DELAY-1] <= lookup_rec;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters, saturating at all-ones
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count  <= '0;
      correct_count <= '0;
    end else if (train_en) begin
      if (branch_count != STAT_MAX) begin
        branch_count <= branch_count + 32'd1;
      end
      if ((resolved.pred == is_taken) && (correct_count != STAT_MAX)) begin
        correct_count <= correct_count + 32'd1;
      end
    end
  end

  assign stat_branch  = branch_count;
  assign stat_correct = correct_count;

endmodule
`default_nettype wire

// File: tb/tb_tournament_chooser.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_chooser
// Purpose  : Directed, self-checking bench for tournament_chooser. A driver
//            applies one vector per cycle and queues the hand-computed
//            expectations; a monitor pops them on the falling edge and
//            compares against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tournament_chooser;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] if_pc;
  logic        gbp_pred;
  logic        lbp_pred;
  logic        is_branch;
  logic        is_taken;
  logic        pred;
  logic        use_global;
  logic [31:0] stat_branch;
  logic [31:0] stat_correct;

  tournament_chooser #(
    .INDEX (12),
    .DELAY (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .if_pc        (if_pc),
    .gbp_pred     (gbp_pred),
    .lbp_pred     (lbp_pred),
    .is_branch    (is_branch),
    .is_taken     (is_taken),
    .pred         (pred),
    .use_global   (use_global),
    .stat_branch  (stat_branch),
    .stat_correct (stat_correct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Negative expectation fields mean "not checked this cycle".
  typedef struct {
    string  name;
    int     eu;
    int     ep;
    longint eb;
    longint ec;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.eu >= 0) begin
          vectors++;
          if (use_global !== e.eu[0]) begin
            miscompares++;
            $display("FAIL %s use_global: got %0b expected %0d", e.name, use_global, e.eu);
          end
        end
        if (e.ep >= 0) begin
          vectors++;
          if (pred !== e.ep[0]) begin
            miscompares++;
            $display("FAIL %s pred: got %0b expected %0d", e.name, pred, e.ep);
          end
        end
        if (e.eb >= 0) begin
          vectors++;
          if (stat_branch !== e.eb[31:0]) begin
            miscompares++;
            $display("FAIL %s stat_branch: got %0h expected %0h", e.name, stat_branch, e.eb);
          end
        end
        if (e.ec >= 0) begin
          vectors++;
          if (stat_correct !== e.ec[31:0]) begin
            miscompares++;
            $display("FAIL %s stat_correct: got %0h expected %0h", e.name, stat_correct, e.ec);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic cyc(input bit rn, input logic [31:0] pc, input bit g, input bit l,
                     input bit br, input bit tk, input bit st, input string nm,
                     input int eu = -1, input int ep = -1,
                     input longint eb = -1, input longint ec = -1);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rn;
    if_pc     = pc;
    gbp_pred  = g;
    lbp_pred  = l;
    is_branch = br;
    is_taken  = tk;
    stall     = st;
    e.name = nm;
    e.eu   = eu;
    e.ep   = ep;
    e.eb   = eb;
    e.ec   = ec;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 32'h0, 0, 0, 0, 0, 0, "idle");
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus (cycle numbers in comments count from first reset release)
  // --------------------------------------------------------------------------
  initial begin : driver
    bit [9:0] t6_taken;
    t6_taken  = 10'b0100100100;
    reset     = 1'b0;
    stall     = 1'b0;
    if_pc     = '0;
    gbp_pred  = 1'b0;
    lbp_pred  = 1'b0;
    is_branch = 1'b0;
    is_taken  = 1'b0;

    // Power-on reset state
    cyc(0, 32'h400, 1, 0, 0, 0, 0, "rst_a", 0, 0, 0, 0);
    cyc(0, 32'h014, 0, 1, 0, 0, 0, "rst_b", 0, 1, 0, 0);

    // T2: train idx 0x100 toward global
    cyc(1, 32'h400, 1, 0, 0, 0, 0, "t2_look0", 0, 0, 0, 0);      // c0
    cyc(1, 32'h400, 1, 0, 0, 0, 0, "t2_look1", 0, 0);            // c1
    idle(5);                                                      // c2-c6
    cyc(1, 32'h0,   0, 0, 1, 1, 0, "t2_res0", -1, -1, 0, 0);      // c7: 01->10
    cyc(1, 32'h400, 1, 0, 1, 1, 0, "t2_cnt10", 1, 1, 1, 0);       // c8: 10->11
    cyc(1, 32'h400, 1, 0, 0, 0, 0, "t2_cnt11", 1, 1, 2, 0);       // c9
    idle(5);                                                      // c10-c14
    cyc(1, 32'h0,   0, 0, 1, 1, 0, "t2_res2", -1, -1, 2, 0);      // c15: hold 11

    // T3: train back toward local, saturate at 00, agreement is neutral
    cyc(1, 32'h400, 0, 1, 0, 0, 0, "t3_sat11", 1, 0, 3, 1);       // c16
    cyc(1, 32'h400, 0, 1, 0, 0, 0, "t3_look1", 1, 0);             // c17
    idle(5);                                                      // c18-c22
    cyc(1, 32'h0,   0, 0, 1, 1, 0, "t3_res0", -1, -1, 3, 1);      // c23: 11->10
    cyc(1, 32'h400, 0, 1, 1, 1, 0, "t3_cnt10", 1, 0, 4, 1);       // c24: 10->01
    cyc(1, 32'h400, 0, 1, 0, 0, 0, "t3_cnt01", 0, 1, 5, 1);       // c25
    idle(5);                                                      // c26-c30
    cyc(1, 32'h0,   0, 0, 1, 1, 0, "t3_res2", -1, -1, 5, 1);      // c31: 01->00
    cyc(1, 32'h400, 1, 1, 1, 1, 0, "t3_cnt00_a", 0, 1, 6, 1);     // c32: hold 00
    cyc(1, 32'h400, 0, 0, 0, 0, 0, "t3_cnt00_b", 0, 0, 7, 2);     // c33
    cyc(1, 32'h400, 1, 0, 0, 0, 0, "t3_look_g", 0, 0);            // c34
    idle(4);                                                      // c35-c38
    cyc(1, 32'h800, 1, 0, 1, 1, 0, "t3_both_right", 0, 0, 7, 2);  // c39
    cyc(1, 32'h800, 1, 0, 1, 1, 0, "t3_both_wrong", 0, 0, 8, 3);  // c40
    cyc(1, 32'h400, 1, 0, 1, 1, 0, "t3_pre_inc", 0, 0, 9, 3);     // c41: 00->01
    cyc(1, 32'h400, 1, 0, 0, 0, 0, "t3_cnt01_again", 0, 0, 10, 3);// c42

    // T4: stall with is_branch high must not train or count
    cyc(1, 32'h800, 1, 0, 0, 0, 0, "t4_look", 0, 0, 10, 3);       // c43
    idle(2);                                                      // c44-c45
    for (int k = 0; k < 5; k++) begin                             // c46-c50
      cyc(1, 32'h014, ~k[0], k[0], 1, 1, 1, "t4_stall", 0, k & 1, 10, 3);
    end
    cyc(1, 32'h800, 1, 0, 0, 0, 0, "t4_release", 0, 0, 10, 3);    // c51
    idle(3);                                                      // c52-c54
    cyc(1, 32'h0,   0, 0, 1, 1, 0, "t4_res", -1, -1, 10, 3);      // c55
    cyc(1, 32'h800, 1, 0, 0, 0, 0, "t4_paired", 1, 1, 11, 3);     // c56

    // T5: same-index read and write in one cycle
    cyc(1, 32'h014, 1, 0, 0, 0, 0, "t5_look", 0, 0);              // c57
    idle(6);                                                      // c58-c63
    cyc(1, 32'h014, 1, 0, 1, 1, 0, "t5_same_cycle", 0, 0, 11, 3); // c64
    cyc(1, 32'h014, 1, 0, 0, 0, 0, "t5_next_cycle", 1, 1, 12, 3); // c65

    // T1: asynchronous reset in the middle of the run
    cyc(0, 32'h800, 1, 0, 0, 0, 0, "t1_mid_a", 0, 0, 0, 0);
    cyc(0, 32'h014, 0, 1, 0, 0, 0, "t1_mid_b", 0, 1, 0, 0);
    cyc(0, 32'h400, 1, 0, 0, 0, 0, "t1_mid_c", 0, 0, 0, 0);

    // T6: 10 resolutions (7 correct) starting against zeroed history
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h0, 0, 0, 1, t6_taken[i], 0, "t6_res", 0, 0);
    end
    cyc(1, 32'h0, 0, 0, 0, 0, 0, "t6_counts", -1, -1, 10, 7);
    cyc(1, 32'h0, 0, 0, 1, 0, 0, "t6_sat_a");
    force dut.branch_count  = 32'hFFFF_FFFE;
    force dut.correct_count = 32'hFFFF_FFFE;
    cyc(1, 32'h0, 0, 0, 1, 0, 0, "t6_sat_b");
    release dut.branch_count;
    release dut.correct_count;
    cyc(1, 32'h0, 0, 0, 1, 0, 0, "t6_sat_c", -1, -1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    cyc(1, 32'h0, 0, 0, 0, 0, 0, "t6_hold",  -1, -1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);

    // Let the monitor drain the queue, bounded
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
